// File: rtl/btb_assoc_array.sv
// Set-associative BTB array: lookup, round-robin allocation and flush sequencer.
// Optional macro BTB_WRITE_BYPASS_EN forwards a same-cycle accepted update to the lookup port.
module btb_assoc_array #(
    parameter int s_index  = 4,
    parameter int s_tag    = 8,
    parameter int s_target = 32,
    parameter int num_ways = 2,
    parameter int s_way    = (num_ways > 1) ? $clog2(num_ways) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [s_index-1:0]  lookup_index,
    input  logic [s_tag-1:0]    lookup_tag,
    output logic                hit,
    output logic [s_way-1:0]    hit_way,
    output logic [s_target-1:0] target_out,
    input  logic                update,
    input  logic [s_index-1:0]  update_index,
    input  logic [s_tag-1:0]    update_tag,
    input  logic [s_target-1:0] update_target,
    input  logic                flush,
    output logic                busy
);

    localparam int num_sets = 1 << s_index;

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    state_t              r_state;
    logic [s_index-1:0]  r_flush_ctr;
    logic [num_ways-1:0] r_valid  [num_sets];
    logic [s_way-1:0]    r_rr     [num_sets];
    logic [s_tag-1:0]    r_tag    [num_sets][num_ways];
    logic [s_target-1:0] r_target [num_sets][num_ways];

    logic [num_ways-1:0] w_lk_match;
    logic [s_way-1:0]    w_lk_way;
    logic [s_target-1:0] w_lk_tgt;
    logic [num_ways-1:0] w_up_match;
    logic                w_up_hit;
    logic [s_way-1:0]    w_up_way;
    logic                w_free_any;
    logic [s_way-1:0]    w_free_way;
    logic [s_way-1:0]    w_sel_way;
    logic [s_way-1:0]    w_next_rr;
    logic                w_accept;
    logic                w_busy;

    assign w_busy = (r_state == FLUSH);
    assign busy   = w_busy;

    always_comb begin
        w_lk_match = '0;
        w_lk_way   = '0;
        w_lk_tgt   = '0;
        for (int w = 0; w < num_ways; w++) begin
            w_lk_match[w] = r_valid[lookup_index][w] &&
                            (r_tag[lookup_index][w] == lookup_tag);
            if (w_lk_match[w]) begin
                w_lk_way = w_lk_way | s_way'(w);
                w_lk_tgt = w_lk_tgt | r_target[lookup_index][w];
            end
        end
    end

    always_comb begin
        w_up_match = '0;
        w_up_way   = '0;
        w_free_any = 1'b0;
        w_free_way = '0;
        for (int w = 0; w < num_ways; w++) begin
            w_up_match[w] = r_valid[update_index][w] &&
                            (r_tag[update_index][w] == update_tag);
            if (w_up_match[w]) begin
                w_up_way = w_up_way | s_way'(w);
            end
        end
        // Descending scan so the lowest invalid way is the last one written
        for (int w = num_ways - 1; w >= 0; w--) begin
            if (!r_valid[update_index][w]) begin
                w_free_any = 1'b1;
                w_free_way = s_way'(w);
            end
        end
    end

    assign w_up_hit  = |w_up_match;
    assign w_accept  = update && !w_busy && !flush;
    assign w_sel_way = w_up_hit   ? w_up_way   :
                       w_free_any ? w_free_way : r_rr[update_index];
    assign w_next_rr = (num_ways == 1) ? '0 : s_way'(w_sel_way + 1'b1);

`ifdef BTB_WRITE_BYPASS_EN
    logic w_bypass;
    assign w_bypass = w_accept && (lookup_index == update_index) &&
                      (lookup_tag == update_tag);
`endif

    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        target_out = '0;
        if (!w_busy) begin
            hit        = |w_lk_match;
            hit_way    = w_lk_way;
            target_out = w_lk_tgt;
        end
`ifdef BTB_WRITE_BYPASS_EN
        if (w_bypass) begin
            hit        = 1'b1;
            hit_way    = w_sel_way;
            target_out = update_target;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_flush_ctr <= '0;
            for (int s = 0; s < num_sets; s++) begin
                r_valid[s] <= '0;
                r_rr[s]    <= '0;
            end
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (flush) begin
                        r_state     <= FLUSH;
                        r_flush_ctr <= '0;
                    end else if (w_accept) begin
                        r_valid[update_index][w_sel_way] <= 1'b1;
                        if (!w_up_hit) begin
                            r_rr[update_index] <= w_next_rr;
                        end
                    end
                end
                FLUSH: begin
                    r_valid[r_flush_ctr] <= '0;
                    r_rr[r_flush_ctr]    <= '0;
                    if (r_flush_ctr == s_index'(num_sets - 1)) begin
                        r_state <= IDLE;
                    end else begin
                        r_flush_ctr <= r_flush_ctr + 1'b1;
                    end
                end
            endcase
        end
    end

    // Tag and target storage carry no reset; valid bits qualify them
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tag[update_index][w_sel_way]    <= update_tag;
            r_target[update_index][w_sel_way] <= update_target;
        end
    end

endmodule

// File: tb/tb_btb_assoc_array.sv
// Directed bench for btb_assoc_array: vector table plus flush, reset and bypass sequences.
module tb_btb_assoc_array;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  lookup_index;
    logic [7:0]  lookup_tag;
    logic        hit;
    logic [0:0]  hit_way;
    logic [31:0] target_out;
    logic        update;
    logic [3:0]  update_index;
    logic [7:0]  update_tag;
    logic [31:0] update_target;
    logic        flush;
    logic        busy;

    int errors = 0;
    int checks = 0;

    btb_assoc_array dut (
        .clk          (clk),
        .rst          (rst),
        .lookup_index (lookup_index),
        .lookup_tag   (lookup_tag),
        .hit          (hit),
        .hit_way      (hit_way),
        .target_out   (target_out),
        .update       (update),
        .update_index (update_index),
        .update_tag   (update_tag),
        .update_target(update_target),
        .flush        (flush),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          upd;
        logic [3:0]  idx;
        logic [7:0]  tag;
        logic [31:0] tgt;
        logic        eh;
        logic [0:0]  ew;
        logic [31:0] et;
        string       nm;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit u, logic [3:0] i, logic [7:0] t,
                                logic [31:0] g, logic h, logic [0:0] w,
                                logic [31:0] e, string n);
        vec_t v;
        v.upd = u; v.idx = i; v.tag = t; v.tgt = g;
        v.eh = h; v.ew = w; v.et = e; v.nm = n;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic look(logic [3:0] i, logic [7:0] t);
        lookup_index = i;
        lookup_tag   = t;
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1; update = 1'b0; flush = 1'b0;
        update_index = '0; update_tag = '0; update_target = '0;
        lookup_index = 4'd3; lookup_tag = 8'h12;
        #2;
        chk("rst_hit", 32'(hit), 0);
        chk("rst_way", 32'(hit_way), 0);
        chk("rst_tgt", target_out, 0);
        chk("rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;

        vecs.push_back(mk(0, 3, 8'h12, 0,      0, 0, 0,      "miss_empty"));
        vecs.push_back(mk(1, 3, 8'h12, 32'h1000, 0, 0, 0,    "u_3_12"));
        vecs.push_back(mk(0, 3, 8'h12, 0,      1, 0, 32'h1000, "hit_3_12"));
        vecs.push_back(mk(0, 4, 8'h12, 0,      0, 0, 0,      "miss_other_set"));
        vecs.push_back(mk(1, 5, 8'hA1, 32'h51, 0, 0, 0,      "u_A1"));
        vecs.push_back(mk(1, 5, 8'hA2, 32'h52, 0, 0, 0,      "u_A2"));
        vecs.push_back(mk(0, 5, 8'hA1, 0,      1, 0, 32'h51, "hit_A1"));
        vecs.push_back(mk(0, 5, 8'hA2, 0,      1, 1, 32'h52, "hit_A2"));
        vecs.push_back(mk(1, 5, 8'hA3, 32'h53, 0, 0, 0,      "u_A3"));
        vecs.push_back(mk(1, 5, 8'hA4, 32'h54, 0, 0, 0,      "u_A4"));
        vecs.push_back(mk(0, 5, 8'hA1, 0,      0, 0, 0,      "miss_A1"));
        vecs.push_back(mk(0, 5, 8'hA2, 0,      0, 0, 0,      "miss_A2"));
        vecs.push_back(mk(0, 5, 8'hA3, 0,      1, 0, 32'h53, "hit_A3"));
        vecs.push_back(mk(0, 5, 8'hA4, 0,      1, 1, 32'h54, "hit_A4"));
        vecs.push_back(mk(1, 5, 8'hA3, 32'h2000, 0, 0, 0,    "u_A3_rw"));
        vecs.push_back(mk(0, 5, 8'hA3, 0,      1, 0, 32'h2000, "hit_A3_rw"));
        vecs.push_back(mk(0, 5, 8'hA4, 0,      1, 1, 32'h54, "hit_A4_kept"));
        // rr_ptr is 0 after A4 went to way 1, and the rewrite left it alone
        vecs.push_back(mk(1, 5, 8'hA5, 32'h55, 0, 0, 0,      "u_A5"));
        vecs.push_back(mk(0, 5, 8'hA5, 0,      1, 0, 32'h55, "hit_A5"));
        vecs.push_back(mk(0, 5, 8'hA4, 0,      1, 1, 32'h54, "hit_A4_last"));
        vecs.push_back(mk(0, 5, 8'hA3, 0,      0, 0, 0,      "miss_A3"));

        foreach (vecs[k]) begin
            @(negedge clk);
            update = vecs[k].upd;
            if (vecs[k].upd) begin
                update_index  = vecs[k].idx;
                update_tag    = vecs[k].tag;
                update_target = vecs[k].tgt;
                #2;
            end else begin
                look(vecs[k].idx, vecs[k].tag);
                chk({vecs[k].nm, "_hit"}, 32'(hit), 32'(vecs[k].eh));
                chk({vecs[k].nm, "_way"}, 32'(hit_way), 32'(vecs[k].ew));
                chk({vecs[k].nm, "_tgt"}, target_out, vecs[k].et);
            end
        end
        @(negedge clk);
        update = 1'b0;

        for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            update = 1'b1;
            update_index = 4'(s);
            update_tag = 8'h40 + 8'(s);
            update_target = 32'h100 + 32'(s);
        end
        @(negedge clk);
        update = 1'b0;
        look(4'd9, 8'h49);
        chk("pre_flush_hit", 32'(hit), 1);
        chk("pre_flush_tgt", target_out, 32'h109);

        @(negedge clk);
        flush = 1'b1;
        update = 1'b1;
        update_index = 4'd7; update_tag = 8'h77; update_target = 32'h7777;
        @(negedge clk);
        flush = 1'b0;
        update = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            flush = (n == 3);
            update = (n == 3);
            update_index = 4'd2; update_tag = 8'h22; update_target = 32'h2222;
            look(4'd9, 8'h49);
            chk("busy_miss", 32'(hit), 0);
            @(negedge clk);
        end
        flush = 1'b0;
        update = 1'b0;
        chk("busy_len", 32'(n), 16);
        for (int s = 0; s < 16; s++) begin
            look(4'(s), 8'h40 + 8'(s));
            chk("post_flush_miss", 32'(hit), 0);
        end
        look(4'd7, 8'h77);
        chk("dropped_upd", 32'(hit), 0);
        look(4'd2, 8'h22);
        chk("ignored_upd", 32'(hit), 0);
        chk("post_flush_busy", 32'(busy), 0);

        @(negedge clk);
        update = 1'b1;
        update_index = 4'd9; update_tag = 8'h49; update_target = 32'h999;
        @(negedge clk);
        update = 1'b0;
        look(4'd9, 8'h49);
        chk("refill_hit", 32'(hit), 1);
        chk("refill_tgt", target_out, 32'h999);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("rflush_busy", 32'(busy), 1);
        repeat (6) @(negedge clk);
        chk("rflush_busy7", 32'(busy), 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(busy), 0);
        look(4'd9, 8'h49);
        chk("rst_mid_hit", 32'(hit), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_resid", 32'(busy), 0);
        look(4'd9, 8'h49);
        chk("rst_mid_valid", 32'(hit), 0);

        @(negedge clk);
        update = 1'b1;
        update_index = 4'd2; update_tag = 8'h33; update_target = 32'h4444;
        look(4'd2, 8'h33);
`ifdef BTB_WRITE_BYPASS_EN
        chk("byp_hit", 32'(hit), 1);
        chk("byp_tgt", target_out, 32'h4444);
        chk("byp_way", 32'(hit_way), 0);
`else
        chk("byp_hit", 32'(hit), 0);
        chk("byp_tgt", target_out, 0);
`endif
        @(negedge clk);
        update = 1'b0;
        look(4'd2, 8'h33);
        chk("byp_next_hit", 32'(hit), 1);
        chk("byp_next_tgt", target_out, 32'h4444);
        chk("byp_next_way", 32'(hit_way), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
